regfile_hazard_controller: RTL

- Sequences access to the 8 x 16-bit register file that feeds the decode stage.
- Keeps a per-register scoreboard of in-flight writes and stalls decode on read-after-write and write-after-write hazards, with same-cycle bypass.
- Arbitrates the single register-file write port between the ALU and memory writeback requesters and drives write_back, write_addr and write_data.

---
 rtl/regfile_hazard_controller.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_hazard_controller.sv
// Register-file access sequencer: per-register pending-write scoreboard with RAW/WAW stall,
// same-cycle writeback bypass, and ALU/memory write-port arbitration with ALU starvation guard.
module regfile_hazard_controller #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int CNT_W      = 2,
  parameter int STARVE_LIM = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              uses_src,
  input  logic              uses_dst,
  input  logic              writes_dst,
  output logic              stall,
  output logic              issue_ack,
  output logic              fwd_src,
  output logic              fwd_dst,
  input  logic              alu_wb_req,
  input  logic [ADDR_W-1:0] alu_wb_addr,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_gnt,
  input  logic              mem_wb_req,
  input  logic [ADDR_W-1:0] mem_wb_addr,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_gnt,
  output logic              write_back,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              sb_error
);

  localparam int NREG = 2**ADDR_W;
  localparam int SW   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SW-1:0]    LIM     = SW'(STARVE_LIM);

  logic [CNT_W-1:0] cnt [NREG];
  logic [SW-1:0]    starve;

  logic [CNT_W-1:0] src_cnt, dst_cnt;
  logic             src_byp, dst_byp, src_haz, dst_haz, structural;

  // Write-port arbitration: memory by default, ALU when alone or starved too long.
  always_comb begin
    alu_wb_gnt = 1'b0;
    mem_wb_gnt = 1'b0;
    if (rst) begin
      if (alu_wb_req && (!mem_wb_req || starve == LIM)) alu_wb_gnt = 1'b1;
      else if (mem_wb_req)                               mem_wb_gnt = 1'b1;
    end
    write_back = alu_wb_gnt | mem_wb_gnt;
    write_addr = '0;
    write_data = '0;
    if (alu_wb_gnt) begin
      write_addr = alu_wb_addr;
      write_data = alu_wb_data;
    end else if (mem_wb_gnt) begin
      write_addr = mem_wb_addr;
      write_data = mem_wb_data;
    end
  end

  // An operand with exactly one pending write is usable if that write commits this cycle.
  always_comb begin
    src_cnt    = cnt[src_addr];
    dst_cnt    = cnt[dst_addr];
    src_byp    = (src_cnt == CNT_ONE) && write_back && (write_addr == src_addr);
    dst_byp    = (dst_cnt == CNT_ONE) && write_back && (write_addr == dst_addr);
    src_haz    = uses_src && (src_cnt != '0) && !src_byp;
    dst_haz    = uses_dst && (dst_cnt != '0) && !dst_byp;
    structural = writes_dst && (dst_cnt == CNT_MAX) &&
                 !(write_back && (write_addr == dst_addr));
    stall      = !rst || (issue_valid && (src_haz || dst_haz || structural));
    issue_ack  = rst && issue_valid && !stall;
    fwd_src    = issue_ack && uses_src && src_byp;
    fwd_dst    = issue_ack && uses_dst && dst_byp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      starve   <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if ((issue_ack && writes_dst && dst_addr == ADDR_W'(i)) &&
            !(write_back && write_addr == ADDR_W'(i)))
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (!(issue_ack && writes_dst && dst_addr == ADDR_W'(i)) &&
                 (write_back && write_addr == ADDR_W'(i)) && cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_ONE;
      end
      if (write_back && cnt[write_addr] == '0) sb_error <= 1'b1;
      if (!alu_wb_req || alu_wb_gnt)            starve <= '0;
      else if (mem_wb_gnt && starve != LIM)     starve <= starve + SW'(1);
    end
  end

endmodule
